// File: rtl/rtmq_tmr_reg.sv
// Countdown-timer register fed by the RTMQ access-flag decoder: aligned bus fields,
// masked/segmented writes, ticked countdown, one-cycle expiry pulse and read-cleared sticky flag.
module rtmq_tmr_reg #(
    parameter int W_REG = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_REG-1:0] alu_res,
    input  logic [W_REG-1:0] alu_msk,
    input  logic [W_REG-1:0] imm_res,
    input  logic             f_read,
    input  logic             f_wrt_alu,
    input  logic             f_wrt_ihi,
    input  logic             f_wrt_ilo,
    input  logic             tick,
    output logic [W_REG-1:0] reg_out,
    output logic             busy,
    output logic             expire,
    output logic             expired
);

    localparam int HALF = W_REG / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [W_REG-1:0] d_res_r;
    logic [W_REG-1:0] d_msk_r;
    logic [W_REG-1:0] d_imm_r;
    logic [W_REG-1:0] cnt_r;
    logic [W_REG-1:0] cnt_nxt_s;
    logic [W_REG-1:0] wval_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic             wr_any_s;
    logic             expire_r;
    logic             expire_nxt_s;
    logic             expired_r;
    logic             expired_nxt_s;
    logic             busy_r;

    // Bus fields arrive one cycle ahead of the decoder flags; delay them to line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_res_r <= {W_REG{1'b0}};
            d_msk_r <= {W_REG{1'b0}};
            d_imm_r <= {W_REG{1'b0}};
        end else begin
            d_res_r <= alu_res;
            d_msk_r <= alu_msk;
            d_imm_r <= imm_res;
        end
    end

    assign wr_any_s = f_wrt_alu | f_wrt_ihi | f_wrt_ilo;

    // Write value: the ALU channel overrides the immediate half-word channels.
    always_comb begin
        wval_s = cnt_r;
        if (f_wrt_alu) begin
            wval_s = (cnt_r & ~d_msk_r) | (d_res_r & d_msk_r);
        end else begin
            if (f_wrt_ihi) begin
                wval_s[W_REG-1:HALF] = d_imm_r[W_REG-1:HALF];
            end else begin
                wval_s[W_REG-1:HALF] = cnt_r[W_REG-1:HALF];
            end
            if (f_wrt_ilo) begin
                wval_s[HALF-1:0] = d_imm_r[HALF-1:0];
            end else begin
                wval_s[HALF-1:0] = cnt_r[HALF-1:0];
            end
        end
    end

    // Next-state, next-count and expiry decision; a write overrides counting in every state.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        expire_nxt_s = 1'b0;
        if (wr_any_s) begin
            cnt_nxt_s   = wval_s;
            state_nxt_s = (wval_s != {W_REG{1'b0}}) ? RUN : IDLE;
        end else begin
            case (state_r)
                RUN: begin
                    if (tick) begin
                        if (cnt_r > W_REG'(1)) begin
                            cnt_nxt_s = cnt_r - W_REG'(1);
                        end else begin
                            cnt_nxt_s    = {W_REG{1'b0}};
                            expire_nxt_s = 1'b1;
                            state_nxt_s  = DONE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                IDLE:    state_nxt_s = IDLE;
                DONE:    state_nxt_s = DONE;
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {W_REG{1'b0}};
                end
            endcase
        end
    end

    // Sticky flag: a same-edge expiry beats the read clear.
    always_comb begin
        if (expire_nxt_s) begin
            expired_nxt_s = 1'b1;
        end else if (f_read) begin
            expired_nxt_s = 1'b0;
        end else begin
            expired_nxt_s = expired_r;
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {W_REG{1'b0}};
            expire_r  <= 1'b0;
            expired_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            expire_r  <= expire_nxt_s;
            expired_r <= expired_nxt_s;
            busy_r    <= (state_nxt_s == RUN);
        end
    end

    assign reg_out = cnt_r;
    assign busy    = busy_r;
    assign expire  = expire_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_rtmq_tmr_reg.sv
// Bench for rtmq_tmr_reg: directed scenarios then random traffic, all checked
// against an abstract model (pending write, running flag, countdown value, sticky flag).
module tb_rtmq_tmr_reg;

    localparam int W = 32;
    localparam int H = W / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] alu_res, alu_msk, imm_res;
    logic         f_read, f_wrt_alu, f_wrt_ihi, f_wrt_ilo, tick;
    logic [W-1:0] reg_out;
    logic         busy, expire, expired;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] m_cnt;
    logic         m_run, m_expire, m_expired;
    logic [W-1:0] m_pres, m_pmsk, m_pimm;

    rtmq_tmr_reg #(.W_REG(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_res(alu_res), .alu_msk(alu_msk), .imm_res(imm_res),
        .f_read(f_read), .f_wrt_alu(f_wrt_alu), .f_wrt_ihi(f_wrt_ihi), .f_wrt_ilo(f_wrt_ilo),
        .tick(tick),
        .reg_out(reg_out), .busy(busy), .expire(expire), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = '0; m_run = 1'b0; m_expire = 1'b0; m_expired = 1'b0;
        m_pres = '0; m_pmsk = '0; m_pimm = '0;
    endtask

    // One clock edge of the model: writes use the bus fields seen one edge earlier.
    task automatic model_step();
        logic [W-1:0] w;
        m_expire = 1'b0;
        if (f_wrt_alu || f_wrt_ihi || f_wrt_ilo) begin
            if (f_wrt_alu) begin
                w = (m_cnt & ~m_pmsk) | (m_pres & m_pmsk);
            end else begin
                w = m_cnt;
                if (f_wrt_ihi) w[W-1:H] = m_pimm[W-1:H];
                if (f_wrt_ilo) w[H-1:0] = m_pimm[H-1:0];
            end
            m_cnt = w;
            m_run = (w != 0);
        end else if (m_run && tick) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_run = 1'b0;
                m_expire = 1'b1;
            end
        end
        if (m_expire) m_expired = 1'b1;
        else if (f_read) m_expired = 1'b0;
        m_pres = alu_res; m_pmsk = alu_msk; m_pimm = imm_res;
    endtask

    task automatic check(input string tag);
        assert (reg_out === m_cnt) else begin
            miscompares++;
            $error("FAIL %s reg_out: observed %h expected %h", tag, reg_out, m_cnt);
        end
        assert (busy === m_run) else begin
            miscompares++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, m_run);
        end
        assert (expire === m_expire) else begin
            miscompares++;
            $error("FAIL %s expire: observed %b expected %b", tag, expire, m_expire);
        end
        assert (expired === m_expired) else begin
            miscompares++;
            $error("FAIL %s expired: observed %b expected %b", tag, expired, m_expired);
        end
    endtask

    task automatic expect_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        vectors++;
        check(tag);
        f_read = 1'b0; f_wrt_alu = 1'b0; f_wrt_ihi = 1'b0; f_wrt_ilo = 1'b0;
    endtask

    task automatic wr_alu(input logic [W-1:0] res, input logic [W-1:0] msk, input string tag);
        alu_res = res; alu_msk = msk;
        cycle(tag);
        f_wrt_alu = 1'b1;
        cycle(tag);
    endtask

    task automatic wr_imm(input logic [W-1:0] imm, input logic hi, input logic lo, input string tag);
        imm_res = imm;
        cycle(tag);
        f_wrt_ihi = hi; f_wrt_ilo = lo;
        cycle(tag);
    endtask

    initial begin
        rst_n = 1'b0; alu_res = '0; alu_msk = '0; imm_res = '0;
        f_read = 1'b0; f_wrt_alu = 1'b0; f_wrt_ihi = 1'b0; f_wrt_ilo = 1'b0; tick = 1'b0;
        model_reset();
        #1;
        vectors++;
        check("reset");
        #8 rst_n = 1'b1;

        // ALU masked write over 0x0000FFFF
        wr_alu(32'h0000_FFFF, 32'hFFFF_FFFF, "alu_pre");
        wr_alu(32'h1234_5678, 32'hFF00_FF00, "alu_msk");
        expect_val("alu_msk_const", reg_out, 32'h1200_56FF);
        expect_val("alu_msk_busy", {31'd0, busy}, 32'd1);

        // Immediate segments
        wr_imm(32'h0000_0003, 1'b0, 1'b1, "imm_lo");
        wr_imm(32'h0001_0000, 1'b1, 1'b0, "imm_hi");
        expect_val("imm_const", reg_out, 32'h0001_0003);
        wr_imm(32'hABCD_0042, 1'b1, 1'b1, "imm_both");

        // Countdown 3,2,1,0 with tick held
        tick = 1'b1;
        wr_alu(32'd3, 32'hFFFF_FFFF, "cd_load");
        expect_val("cd_3", reg_out, 32'd3);
        cycle("cd"); expect_val("cd_2", reg_out, 32'd2);
        cycle("cd"); expect_val("cd_1", reg_out, 32'd1);
        cycle("cd"); expect_val("cd_0", reg_out, 32'd0);
        expect_val("cd_pulse", {30'd0, expire, expired}, 32'd3);
        cycle("cd_after");
        expect_val("cd_pulse_end", {31'd0, expire}, 32'd0);

        // Tick toggling
        tick = 1'b0;
        wr_alu(32'd4, 32'hFFFF_FFFF, "tog_load");
        for (int i = 0; i < 10; i++) begin
            tick = i[0];
            cycle("tog");
        end

        // Read clear, reg_out unchanged
        f_read = 1'b1;
        cycle("rdclr");
        expect_val("rdclr_flag", {31'd0, expired}, 32'd0);

        // Read on the expiry edge: set wins
        tick = 1'b1;
        wr_alu(32'd2, 32'hFFFF_FFFF, "rdexp_load");
        cycle("rdexp");
        f_read = 1'b1;
        cycle("rdexp_edge");
        expect_val("rdexp_set_wins", {30'd0, expire, expired}, 32'd3);

        // Write 7 on the edge where the count would reach 0
        wr_alu(32'd2, 32'hFFFF_FFFF, "wr7_load");
        imm_res = 32'd7;
        cycle("wr7_bus");
        f_wrt_ilo = 1'b1;
        cycle("wr7_edge");
        expect_val("wr7_val", reg_out, 32'd7);
        expect_val("wr7_noexp", {30'd0, expire, busy}, 32'd1);

        // Write of 0 goes idle without expiry
        wr_alu(32'd0, 32'hFFFF_FFFF, "wr0");
        expect_val("wr0_idle", {30'd0, busy, expire}, 32'd0);

        // Asynchronous reset mid-count
        tick = 1'b0;
        wr_alu(32'd5, 32'hFFFF_FFFF, "rst_load");
        #2 rst_n = 1'b0;
        #1 model_reset();
        vectors++;
        check("async_rst");
        tick = 1'b1;
        cycle("rst_hold");
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle("post_rst");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            alu_res   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 6);
            alu_msk   = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            imm_res   = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 5);
            tick      = ($urandom_range(0, 3) != 0);
            f_read    = ($urandom_range(0, 7) == 0);
            f_wrt_alu = ($urandom_range(0, 9) == 0);
            f_wrt_ihi = ($urandom_range(0, 11) == 0);
            f_wrt_ilo = ($urandom_range(0, 7) == 0);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
